// File: rtl/elev_pkg.sv
// Shared constants for the elevator request queue and motion controller.
package elev_pkg;

  // Outcome of an accepted request, reported for one cycle on ins_code
  localparam logic [1:0] INS_NONE  = 2'b00;
  localparam logic [1:0] INS_DUP   = 2'b01;
  localparam logic [1:0] INS_TAIL  = 2'b10;
  localparam logic [1:0] INS_FRONT = 2'b11;

  // Travel direction encoding used on dir_up
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elev_on_the_way.sv
// Combinational on-the-way test: is the requested floor strictly between
// the car's current floor and the head destination in the travel direction?
module elev_on_the_way
  import elev_pkg::*;
#(
  parameter int FLOOR_W = 3
) (
  input  logic [FLOOR_W-1:0] req_floor,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic [FLOOR_W-1:0] head_floor,
  input  logic               dir_up,
  output logic               front
);

  // Strict unsigned compares: a request at the current or head floor is not on the way
  always_comb begin
    if (dir_up == DIR_UP)
      front = (cur_floor < req_floor) && (req_floor < head_floor);
    else
      front = (head_floor < req_floor) && (req_floor < cur_floor);
  end

endmodule

// File: rtl/elevator_request_queue.sv
// Elevator destination queue: DEPTH-entry shift register with on-the-way
// front insertion. Optional duplicate filtering is enabled by defining
// ELEV_DUP_FILTER_EN; without it duplicates are stored like any request.
module elevator_request_queue
  import elev_pkg::*;
#(
  parameter int FLOORS  = 8,
  parameter int DEPTH   = 4,
  parameter int FLOOR_W = $clog2(FLOORS),
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               dir_up,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  output logic               req_ready,
  input  logic               pop,
  output logic               head_valid,
  output logic [FLOOR_W-1:0] head_floor,
  output logic [CNT_W-1:0]   count,
  output logic [1:0]         ins_code,
  output logic               range_err
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [31:0]      FLOORS_U = 32'(FLOORS);

  logic [FLOOR_W-1:0] ent      [DEPTH];
  logic [FLOOR_W-1:0] post_ent [DEPTH];
  logic [FLOOR_W-1:0] ent_n    [DEPTH];
  logic [CNT_W-1:0]   cnt, post_cnt, cnt_n;
  logic [1:0]         ins_q, ins_n;
  logic               rerr_q;
  logic               accept, do_pop, out_of_range, dup_hit, otw, front, store;
  logic [31:0]        req_ext;

  // Ready depends only on reset and the registered count, never on pop
  assign req_ready    = !reset && (cnt != FULL_CNT);
  assign accept       = req_valid && req_ready;
  assign do_pop       = pop && (cnt != '0);
  assign post_cnt     = do_pop ? (cnt - CNT_W'(1)) : cnt;
  assign req_ext      = {{(32-FLOOR_W){1'b0}}, req_floor};
  assign out_of_range = req_ext >= FLOORS_U;

  // Queue contents as seen after this cycle's pop; the vacated top slot reads as zero
  always_comb begin
    for (int i = 0; i < DEPTH; i++) post_ent[i] = ent[i];
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) post_ent[i] = ent[i+1];
      post_ent[DEPTH-1] = '0;
    end
  end

  // Duplicate detection against the occupied post-pop entries
  always_comb begin
    dup_hit = 1'b0;
`ifdef ELEV_DUP_FILTER_EN
    for (int i = 0; i < DEPTH; i++)
      if ((CNT_W'(i) < post_cnt) && (post_ent[i] == req_floor)) dup_hit = 1'b1;
`endif
  end

  elev_on_the_way #(.FLOOR_W(FLOOR_W)) u_on_the_way (
    .req_floor  (req_floor),
    .cur_floor  (cur_floor),
    .head_floor (post_ent[0]),
    .dir_up     (dir_up),
    .front      (otw)
  );

  assign front = otw && (post_cnt != '0);
  assign store = accept && !out_of_range && !dup_hit;

  // Next queue contents, count and one-cycle event code
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_n[i] = post_ent[i];
    if (store) begin
      if (front) begin
        ent_n[0] = req_floor;
        for (int i = 1; i < DEPTH; i++) ent_n[i] = post_ent[i-1];
      end else begin
        for (int i = 0; i < DEPTH; i++)
          if (CNT_W'(i) == post_cnt) ent_n[i] = req_floor;
      end
    end
    cnt_n = post_cnt + CNT_W'(store);
    ins_n = INS_NONE;
    if (accept && !out_of_range) begin
      if (dup_hit)    ins_n = INS_DUP;
      else if (front) ins_n = INS_FRONT;
      else            ins_n = INS_TAIL;
    end
  end

  // State register: queue, count and event pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      cnt    <= '0;
      ins_q  <= INS_NONE;
      rerr_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= ent_n[i];
      cnt    <= cnt_n;
      ins_q  <= ins_n;
      rerr_q <= accept && out_of_range;
    end
  end

  assign head_valid = (cnt != '0);
  assign head_floor = ent[0];
  assign count      = cnt;
  assign ins_code   = ins_q;
  assign range_err  = rerr_q;

endmodule

// File: tb/tb_elevator_request_queue.sv
// Directed testbench for elevator_request_queue. Main instance FLOORS=8,
// DEPTH=4; a second instance with FLOORS=9 exercises out-of-range requests.
module tb_elevator_request_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] cur_floor, req_floor;
  logic       dir_up, req_valid, pop;
  logic       req_ready, head_valid, range_err;
  logic [2:0] head_floor, count;
  logic [1:0] ins_code;

  logic [3:0] r_cur, r_req, r_head;
  logic       r_dir, r_valid, r_pop, r_ready, r_head_valid, r_rerr;
  logic [2:0] r_count;
  logic [1:0] r_ins;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  elevator_request_queue #(.FLOORS(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cur_floor(cur_floor), .dir_up(dir_up),
    .req_valid(req_valid), .req_floor(req_floor), .req_ready(req_ready),
    .pop(pop), .head_valid(head_valid), .head_floor(head_floor),
    .count(count), .ins_code(ins_code), .range_err(range_err)
  );

  elevator_request_queue #(.FLOORS(9), .DEPTH(4)) dut_r (
    .clk(clk), .reset(reset), .cur_floor(r_cur), .dir_up(r_dir),
    .req_valid(r_valid), .req_floor(r_req), .req_ready(r_ready),
    .pop(r_pop), .head_valid(r_head_valid), .head_floor(r_head),
    .count(r_count), .ins_code(r_ins), .range_err(r_rerr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] f);
    req_valid = 1'b1;
    req_floor = f;
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  task automatic r_push(input logic [3:0] f);
    r_valid = 1'b1;
    r_req   = f;
    step();
    r_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cur_floor = '0; req_floor = '0; dir_up = 1'b1; req_valid = 1'b0; pop = 1'b0;
    r_cur = '0; r_req = '0; r_dir = 1'b1; r_valid = 1'b0; r_pop = 1'b0;
    step(); step();
    check("rst_count", count, 0);
    check("rst_head_valid", head_valid, 0);
    check("rst_head_floor", head_floor, 0);
    check("rst_ins", ins_code, 0);
    check("rst_range_err", range_err, 0);
    check("rst_ready", req_ready, 0);
    reset = 1'b0; #1;
    check("ready_after_rst", req_ready, 1);

    // Upward travel from floor 1: 6 appended, then 3 goes in front
    dir_up = 1'b1; cur_floor = 3'd1;
    push(3'd6);
    check("up_first_ins", ins_code, 2'b10);
    check("up_first_count", count, 1);
    check("up_first_head", head_floor, 6);
    push(3'd3);
    check("up_front_ins", ins_code, 2'b11);
    check("up_front_head", head_floor, 3);
    check("up_front_count", count, 2);
    step();
    check("ins_pulse_clears", ins_code, 2'b00);

    // Pop [3,6] and push 4 in the same cycle at floor 3
    cur_floor = 3'd3; pop = 1'b1; req_valid = 1'b1; req_floor = 3'd4;
    step();
    pop = 1'b0; req_valid = 1'b0;
    check("poppush_ins", ins_code, 2'b11);
    check("poppush_head", head_floor, 4);
    check("poppush_count", count, 2);
    // Request equal to current floor is not on the way
    push(3'd3);
    check("eq_cur_ins", ins_code, 2'b10);
    check("eq_cur_count", count, 3);
    do_pop();
    check("drain1_head", head_floor, 6);
    do_pop();
    check("drain2_head", head_floor, 3);
    do_pop();
    check("drain3_count", count, 0);
    check("drain3_head_valid", head_valid, 0);
    do_pop();
    check("pop_empty_count", count, 0);

    // Downward travel from floor 7
    dir_up = 1'b0; cur_floor = 3'd7;
    push(3'd2);
    check("dn_first_ins", ins_code, 2'b10);
    push(3'd5);
    check("dn_front_ins", ins_code, 2'b11);
    check("dn_front_head", head_floor, 5);
    push(3'd1);
    check("dn_tail_ins", ins_code, 2'b10);
    check("dn_tail_count", count, 3);
    do_pop();
    check("dn_pop1_head", head_floor, 2);
    do_pop();
    check("dn_pop2_head", head_floor, 1);
    do_pop();
    check("dn_empty", head_valid, 0);

    // Fill the queue, hold a request while full, then pop to let it in
    dir_up = 1'b1; cur_floor = 3'd0;
    for (int i = 1; i <= 4; i++) push(3'(i));
    check("full_count", count, 4);
    check("full_ready", req_ready, 0);
    req_valid = 1'b1; req_floor = 3'd5;
    step();
    check("held_count", count, 4);
    check("held_ins", ins_code, 2'b00);
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("full_pop_count", count, 3);
    check("full_pop_ready", req_ready, 1);
    check("full_pop_head", head_floor, 2);
    step();
    req_valid = 1'b0;
    check("held_accept_count", count, 4);
    check("held_accept_ins", ins_code, 2'b10);
    for (int i = 0; i < 3; i++) do_pop();
    check("held_tail_head", head_floor, 5);
    do_pop();
    check("full_drained", count, 0);

    // Duplicate handling on [3,6]
    cur_floor = 3'd1;
    push(3'd6);
    push(3'd3);
    push(3'd6);
`ifdef ELEV_DUP_FILTER_EN
    check("dup_ins", ins_code, 2'b01);
    check("dup_count", count, 2);
`else
    check("dup_ins", ins_code, 2'b10);
    check("dup_count", count, 3);
`endif
    check("dup_head", head_floor, 3);

    // Reset mid-operation with a request pending
    reset = 1'b1; step(); reset = 1'b0; step();
    cur_floor = 3'd0;
    push(3'd1); push(3'd2); push(3'd3);
    check("prerst_count", count, 3);
    reset = 1'b1; req_valid = 1'b1; req_floor = 3'd4;
    #1;
    check("midrst_ready", req_ready, 0);
    step();
    check("midrst_count", count, 0);
    check("midrst_head_valid", head_valid, 0);
    check("midrst_ins", ins_code, 0);
    step();
    check("midrst_hold_count", count, 0);
    reset = 1'b0; req_valid = 1'b0;
    step();
    check("postrst_count", count, 0);
    check("postrst_head_valid", head_valid, 0);

    // Out-of-range requests on the FLOORS=9 instance
    r_dir = 1'b1; r_cur = 4'd0;
    r_push(4'd2);
    check("r_first_count", r_count, 1);
    r_push(4'd9);
    check("r_range_err", r_rerr, 1);
    check("r_range_ins", r_ins, 2'b00);
    check("r_range_count", r_count, 1);
    step();
    check("r_range_clears", r_rerr, 0);
    r_push(4'd8);
    check("r_top_ok_err", r_rerr, 0);
    check("r_top_ok_ins", r_ins, 2'b10);
    check("r_top_ok_count", r_count, 2);
    check("r_top_ok_head", r_head, 2);
    r_push(4'd15);
    check("r_max_err", r_rerr, 1);
    check("r_max_count", r_count, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
